// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants, widths and request layout
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 3;
    localparam int ENTRY_W = 2 * DATA_W + OP_W;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SRL = 3'b100;
    localparam logic [OP_W-1:0] OP_SRA = 3'b101;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } req_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   ALUOp,
    output logic [DATA_W-1:0] C
);

    logic big_shift;

    // Shift amount is the whole of B, so anything >= 32 saturates.
    assign big_shift = |B[DATA_W-1:5];

    always_comb begin
        C = '0;
        case (ALUOp)
            OP_ADD: C = A + B;
            OP_SUB: C = A - B;
            OP_AND: C = A & B;
            OP_OR:  C = A | B;
            OP_SRL: C = big_shift ? '0 : (A >> B[4:0]);
            OP_SRA: C = big_shift ? {DATA_W{A[DATA_W-1]}}
                                  : DATA_W'($signed(A) >>> B[4:0]);
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy counter and sync clear
module sync_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == CNT_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q;
        if (do_push && !do_pop) level_d = level_q + CNT_W'(1);
        if (!do_push && do_pop) level_d = level_q - CNT_W'(1);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - request FIFO feeding an ALU with a registered result stage
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_c,
    output logic [OP_W-1:0]   out_op,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  level
);

    req_t              wr_req, head;
    logic [ENTRY_W-1:0] head_raw;
    logic              fifo_full, fifo_empty;
    logic              accept, push, pop;
    logic [DATA_W-1:0] alu_c;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_c_q, out_c_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic              err_q, err_d;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready && !clr;
    assign push     = accept && is_legal_op(in_op);
    assign pop      = !fifo_empty && (!out_valid_q || out_ready);
    assign wr_req   = '{a: in_a, b: in_b, op: in_op};
    assign head     = req_t'(head_raw);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .wdata   (wr_req),
        .rdata   (head_raw),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    alu u_alu (
        .A     (head.a),
        .B     (head.b),
        .ALUOp (head.op),
        .C     (alu_c)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_c_d     = out_c_q;
        out_op_d    = out_op_q;
        err_d       = accept && !is_legal_op(in_op);
        if (clr) begin
            out_valid_d = 1'b0;
        end else if (pop) begin
            out_valid_d = 1'b1;
            out_c_d     = alu_c;
            out_op_d    = head.op;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_op_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_op_q    <= out_op_d;
            err_q       <= err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_c       = out_c_q;
    assign out_op      = out_op_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed table-driven bench for alu_issue_queue
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        reset_n, clr, in_valid, in_ready, out_valid, out_ready, err_illegal;
    logic [31:0] in_a, in_b, out_c;
    logic [2:0]  in_op, out_op;
    logic [2:0]  level;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c       (out_c),
        .out_op      (out_op),
        .err_illegal (err_illegal),
        .level       (level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n_acc;
        logic acc_now;

        vecs[0] = '{"add",      32'd100,        32'd99,         3'b000, 32'd199};
        vecs[1] = '{"sub",      32'd100,        32'd99,         3'b001, 32'd1};
        vecs[2] = '{"and",      32'h00ff00ff,   32'hff00ff00,   3'b010, 32'h00000000};
        vecs[3] = '{"or",       32'h00ff00ff,   32'hff00ff00,   3'b011, 32'hffffffff};
        vecs[4] = '{"srl12",    32'h0fffffff,   32'd12,         3'b100, 32'h0000ffff};
        vecs[5] = '{"srl32",    32'hffffffff,   32'd32,         3'b100, 32'h00000000};
        vecs[6] = '{"sra12neg", 32'hefffffff,   32'd12,         3'b101, 32'hfffeffff};
        vecs[7] = '{"sra12pos", 32'h3fffffff,   32'd12,         3'b101, 32'h0003ffff};
        vecs[8] = '{"sra32neg", 32'hffffffff,   32'd32,         3'b101, 32'hffffffff};
        vecs[9] = '{"sra32pos", 32'h3fffffff,   32'd32,         3'b101, 32'h00000000};

        reset_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        #2;
        chk("reset_level",     32'(level),     32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_c",     out_c,          32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_err",       32'(err_illegal), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single requests: one cycle from accept to out_valid.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op;
            tick();
            in_valid = 1'b0;
            chk({vecs[i].name, "_level_after_accept"}, 32'(level), 32'd1);
            chk({vecs[i].name, "_not_valid_yet"}, 32'(out_valid), 32'd0);
            tick();
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, "_c"},     out_c,          vecs[i].exp);
            chk({vecs[i].name, "_op"},    32'(out_op),    32'(vecs[i].op));
            tick();
            chk({vecs[i].name, "_drained"}, 32'(out_valid), 32'd0);
        end

        // Backpressure: six requests offered with the consumer stalled.
        out_ready = 1'b0;
        n_acc = 0;
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd0; in_op = 3'b000;
        for (int c = 0; c < 8; c++) begin
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) begin
                n_acc++;
                in_a = 32'(n_acc + 1);
            end
        end
        chk("bp_accepted", 32'(n_acc),     32'd5);
        chk("bp_level",    32'(level),     32'd4);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_valid",    32'(out_valid), 32'd1);
        chk("bp_c_hold",   out_c,          32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_res%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_res%0d_c", k),     out_c,          32'(k + 1));
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) begin
                n_acc++;
                if (n_acc == 6) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("bp_sixth_accepted", 32'(n_acc),     32'd6);
        chk("bp_drained_valid",  32'(out_valid), 32'd0);
        chk("bp_drained_level",  32'(level),     32'd0);

        // Illegal opcode followed by a legal add.
        in_valid = 1'b1; in_a = 32'd0; in_b = 32'd0; in_op = 3'b110;
        tick();
        chk("ill_err_pulse", 32'(err_illegal), 32'd1);
        chk("ill_level",     32'(level),       32'd0);
        in_a = 32'd2; in_b = 32'd3; in_op = 3'b000;
        tick();
        in_valid = 1'b0;
        chk("ill_err_clears", 32'(err_illegal), 32'd0);
        chk("ill_level_add",  32'(level),       32'd1);
        chk("ill_no_result",  32'(out_valid),   32'd0);
        tick();
        chk("ill_add_valid", 32'(out_valid), 32'd1);
        chk("ill_add_c",     out_c,          32'd5);
        tick();
        chk("ill_only_one", 32'(out_valid), 32'd0);

        // Clear with three queued, one in the output and a same-cycle request.
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in_a = 32'(10 * (j + 1)); in_b = 32'd0; in_op = 3'b000;
            tick();
        end
        chk("clr_pre_level", 32'(level),     32'd3);
        chk("clr_pre_valid", 32'(out_valid), 32'd1);
        clr = 1'b1; in_a = 32'd7;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_level",    32'(level),     32'd0);
        chk("clr_valid",    32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("clr_dropped_valid", 32'(out_valid), 32'd0);
        chk("clr_dropped_level", 32'(level),     32'd0);

        // Asynchronous reset while full.
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1; in_a = 32'd9; in_b = 32'd1; in_op = 3'b001;
            tick();
        end
        in_valid = 1'b0;
        chk("ar_pre_level", 32'(level),  32'd4);
        chk("ar_pre_op",    32'(out_op), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_level",    32'(level),     32'd0);
        chk("ar_valid",    32'(out_valid), 32'd0);
        chk("ar_out_c",    out_c,          32'd0);
        chk("ar_out_op",   32'(out_op),    32'd0);
        chk("ar_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_op = 3'b000;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ar_fresh_valid", 32'(out_valid), 32'd1);
        chk("ar_fresh_c",     out_c,          32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
